// File: rtl/get_digests_requester_if.sv
// Request/response bus between the GET_DIGESTS requester and the message transport.
// The requester drives the request side; the transport drives the response side.
interface get_digests_requester_if #(
  parameter int PAYLOAD_W = 2048
);
  logic [31:0]          req_header;
  logic                 req_valid;
  logic                 rsp_valid;
  logic [31:0]          rsp_header;
  logic [PAYLOAD_W-1:0] rsp_payload;

  modport master (
    output req_header, req_valid,
    input  rsp_valid, rsp_header, rsp_payload
  );

  modport slave (
    input  req_header, req_valid,
    output rsp_valid, rsp_header, rsp_payload
  );
endinterface

// File: rtl/get_digests_requester.sv
// GET_DIGESTS initiator: issues the request, awaits DIGESTS, validates it and extracts one slot digest.
// Optional GET_DIGESTS_RETRY_EN: re-issue the request on timeout, up to 2 retries.
module get_digests_requester #(
  parameter logic [7:0] PROTOCOL_VERSION = 8'h01,
  parameter int         TIMEOUT_CYCLES   = 1000,
  parameter int         DIGEST_W         = 256,
  parameter int         PAYLOAD_W        = 2048
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          slot_sel,
  get_digests_requester_if.master bus,
  output logic [DIGEST_W-1:0] digest,
  output logic [7:0]          slot_mask,
  output logic                done,
  output logic                error,
  output logic [2:0]          err_code,
  output logic                busy,
  output logic [2:0]          dbg_state,
  output logic [7:0]          dbg_param1
);

  // Handshake: req_valid and rsp_valid are single-cycle strobes with no back-pressure;
  // the header/payload they qualify is only meaningful in the cycle the strobe is high.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]     E_NONE    = 3'd0;
  localparam logic [2:0]     E_TIMEOUT = 3'd1;
  localparam logic [2:0]     E_VERSION = 3'd2;
  localparam logic [2:0]     E_MSGTYPE = 3'd3;
  localparam logic [2:0]     E_SLOT    = 3'd4;

  state_t               state_q, state_d;
  logic [2:0]           slot_q, slot_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [31:0]          hdr_q, hdr_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [DIGEST_W-1:0]  digest_q, digest_d;
  logic [2:0]           err_q, err_d;
`ifdef GET_DIGESTS_RETRY_EN
  logic [1:0]           retry_q, retry_d;
`endif

  logic [3:0]           k;
  logic [PAYLOAD_W-1:0] shifted;
  logic [DIGEST_W-1:0]  digest_pick;

  // Digests are packed densely: the selected one sits after every populated slot below it.
  always_comb begin
    k = '0;
    for (int i = 0; i < 8; i++) begin
      if ((3'(i) < slot_q) && hdr_q[i]) k = k + 4'd1;
    end
    shifted     = payload_q << (k * DIGEST_W);
    digest_pick = shifted[PAYLOAD_W-1 -: DIGEST_W];
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    payload_d = payload_q;
    digest_d  = digest_q;
    err_d     = err_q;
`ifdef GET_DIGESTS_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          slot_d   = slot_sel;
          err_d    = E_NONE;
          digest_d = '0;
          hdr_d    = '0;
`ifdef GET_DIGESTS_RETRY_EN
          retry_d  = '0;
`endif
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.rsp_valid) begin
          hdr_d     = bus.rsp_header;
          payload_d = bus.rsp_payload;
          state_d   = S_CHECK;
        end else if (cnt_q == CNT_LAST) begin
`ifdef GET_DIGESTS_RETRY_EN
          if (retry_q != 2'd2) begin
            retry_d = retry_q + 2'd1;
            state_d = S_REQ;
          end else begin
            err_d   = E_TIMEOUT;
            state_d = S_ERR;
          end
`else
          err_d   = E_TIMEOUT;
          state_d = S_ERR;
`endif
        end
      end
      S_CHECK: begin
        if (hdr_q[31:24] != PROTOCOL_VERSION) begin
          err_d   = E_VERSION;
          state_d = S_ERR;
        end else if (hdr_q[23:16] != 8'h01) begin
          err_d   = E_MSGTYPE;
          state_d = S_ERR;
        end else if (!hdr_q[slot_q]) begin
          err_d   = E_SLOT;
          state_d = S_ERR;
        end else begin
          digest_d = digest_pick;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      cnt_q     <= '0;
      hdr_q     <= '0;
      payload_q <= '0;
      digest_q  <= '0;
      err_q     <= '0;
`ifdef GET_DIGESTS_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      payload_q <= payload_d;
      digest_q  <= digest_d;
      err_q     <= err_d;
`ifdef GET_DIGESTS_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign bus.req_valid  = (state_q == S_REQ);
  assign bus.req_header = bus.req_valid ? {PROTOCOL_VERSION, 8'h81, 16'h0000} : 32'h0;
  assign digest         = digest_q;
  assign slot_mask      = hdr_q[7:0];
  assign err_code       = err_q;
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERR);
  assign busy           = (state_q != S_IDLE);
  assign dbg_state      = state_q;
  assign dbg_param1     = hdr_q[15:8];

endmodule

// File: tb/tb_get_digests_requester.sv
// Randomized scoreboard bench for get_digests_requester: a driver issues exchanges and queues the
// expected outcome from a slot-level model; a negedge monitor checks every done/error and request.
module tb_get_digests_requester;

  localparam int T  = 16;
  localparam int EW = 300;  // {cycle[31:0], err[2:0], mask[7:0], digest[255:0], is_done}

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    slot_sel = '0;
  logic [255:0]  digest;
  logic [7:0]    slot_mask;
  logic          done, error, busy;
  logic [2:0]    err_code;
  logic [2:0]    dbg_state;
  logic [7:0]    dbg_param1;

  get_digests_requester_if #(.PAYLOAD_W(2048)) bus ();

  get_digests_requester #(
    .PROTOCOL_VERSION(8'h01), .TIMEOUT_CYCLES(T), .DIGEST_W(256), .PAYLOAD_W(2048)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .slot_sel(slot_sel), .bus(bus),
    .digest(digest), .slot_mask(slot_mask), .done(done), .error(error),
    .err_code(err_code), .busy(busy), .dbg_state(dbg_state), .dbg_param1(dbg_param1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            req_cnt  = 0;
  int            exp_req  = 0;
  logic [255:0]  dg[8];

  task automatic chk(input string name, input logic [299:0] got, input logic [299:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: digest i of the payload is the i-th populated slot counting up from slot 0.
  function automatic logic [EW-1:0] model(input logic [2:0] slot, input logic [7:0] ver,
                                          input logic [7:0] mt, input logic [7:0] mask,
                                          input bit respond, input int delay, input int c0);
    logic [31:0]  c;
    logic [2:0]   e;
    logic [7:0]   m;
    logic [255:0] d;
    logic         ok;
    int           below;
    e = 3'd0; m = 8'h00; d = '0; ok = 1'b0;
    if (!respond) begin
      e = 3'd1;
`ifdef GET_DIGESTS_RETRY_EN
      c = 32'(c0 + 3 * (T + 1) + 1);
`else
      c = 32'(c0 + T + 2);
`endif
    end else begin
      c = 32'(c0 + 4 + delay);
      m = mask;
      if (ver != 8'h01) e = 3'd2;
      else if (mt != 8'h01) e = 3'd3;
      else if (!mask[slot]) e = 3'd4;
      else begin
        below = 0;
        for (int s = 0; s < int'(slot); s++) if (mask[s]) below++;
        d  = dg[below];
        ok = 1'b1;
      end
    end
    return {c, e, m, d, ok};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_random_dg();
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 8; w++) dg[i][w*32 +: 32] = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 4 * T + 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, 300'(busy), 300'(0));
  endtask

  task automatic do_txn(input logic [2:0] slot, input logic [7:0] ver, input logic [7:0] mt,
                        input logic [7:0] mask, input bit respond, input int delay,
                        input bit junk_in_req, input bit poke_start, input string name);
    logic [2047:0] payload;
    for (int i = 0; i < 8; i++) payload[2047 - 256*i -: 256] = dg[i];
    @(posedge clk); #1;
    start = 1'b1; slot_sel = slot;
    exp_q.push_back(model(slot, ver, mt, mask, respond, delay, cyc));
`ifdef GET_DIGESTS_RETRY_EN
    exp_req += respond ? 1 : 3;
`else
    exp_req += 1;
`endif
    @(posedge clk); #1;
    start = 1'b0; slot_sel = $urandom_range(0, 7);
    if (junk_in_req) begin
      bus.rsp_valid  = 1'b1;
      bus.rsp_header = 32'hFF_81_00_00;
      bus.rsp_payload = '1;
    end
    @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
    if (respond) begin
      for (int i = 0; i < delay; i++) begin
        if (poke_start && i == 0) begin
          start = 1'b1; slot_sel = ~slot;
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      bus.rsp_valid   = 1'b1;
      bus.rsp_header  = {ver, mt, 8'($urandom_range(0, 255)), mask};
      bus.rsp_payload = payload;
      @(posedge clk); #1;
      bus.rsp_valid = 1'b0;
    end
    wait_idle(name);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_digest"},   300'(digest),         300'(0));
    chk({name, "_mask"},     300'(slot_mask),      300'(0));
    chk({name, "_err_code"}, 300'(err_code),       300'(0));
    chk({name, "_flags"},    300'({done, error, busy, bus.req_valid}), 300'(0));
    chk({name, "_req_hdr"},  300'(bus.req_header), 300'(0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset) begin
      if (bus.req_valid) begin
        req_cnt++;
        chk("req_header", 300'(bus.req_header), 300'(32'h01810000));
      end
      if (done || error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 300'({done, error}), 300'(0));
        end else begin
          e = exp_q.pop_front();
          chk("done",     300'(done),      300'(e[0]));
          chk("error",    300'(error),     300'(!e[0]));
          chk("digest",   300'(digest),    300'(e[256:1]));
          chk("slot_mask",300'(slot_mask), 300'(e[264:257]));
          chk("err_code", 300'(err_code),  300'(e[267:265]));
          chk("cycle",    300'(cyc),       300'(e[299:268]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.rsp_valid   = 1'b0;
    bus.rsp_header  = '0;
    bus.rsp_payload = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // nominal, immediate response
    for (int i = 0; i < 8; i++) dg[i] = '0;
    dg[0] = {32{8'hA5}};
    do_txn(3'd0, 8'h01, 8'h01, 8'h01, 1'b1, 0, 1'b0, 1'b0, "nominal");

    // packed extraction
    fill_random_dg();
    do_txn(3'd5, 8'h01, 8'h01, 8'b0010_0101, 1'b1, 1, 1'b0, 1'b0, "packed");

    // header errors
    do_txn(3'd0, 8'h02, 8'h01, 8'h01, 1'b1, 0, 1'b0, 1'b0, "bad_version");
    do_txn(3'd0, 8'h01, 8'h81, 8'h01, 1'b1, 2, 1'b0, 1'b0, "bad_msgtype");
    do_txn(3'd3, 8'h01, 8'h01, 8'h01, 1'b1, 0, 1'b0, 1'b0, "slot_empty");

    // timeout, and response landing on the timeout cycle
    do_txn(3'd1, 8'h01, 8'h01, 8'hFF, 1'b0, 0, 1'b0, 1'b0, "timeout");
    fill_random_dg();
    do_txn(3'd7, 8'h01, 8'h01, 8'hFF, 1'b1, T - 1, 1'b0, 1'b0, "resp_on_timeout");

    // response strobe while idle must be ignored
    @(posedge clk); #1;
    bus.rsp_valid = 1'b1; bus.rsp_header = 32'h01010001;
    repeat (2) @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_rsp_busy", 300'(busy), 300'(0));

    // junk during REQ, start while busy
    fill_random_dg();
    do_txn(3'd2, 8'h01, 8'h01, 8'b0000_0110, 1'b1, 3, 1'b1, 1'b1, "junk_and_poke");

    // reset while waiting
    @(posedge clk); #1;
    start = 1'b1; slot_sel = 3'd0;
    exp_req += 1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 300'(busy), 300'(1));
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    fill_random_dg();
    do_txn(3'd4, 8'h01, 8'h01, 8'h10, 1'b1, 0, 1'b0, 1'b0, "after_reset");

    // randomized exchanges
    for (int n = 0; n < 40; n++) begin
      logic [2:0] s;
      logic [7:0] m, v, t;
      bit         r;
      int         d;
      s = 3'($urandom_range(0, 7));
      m = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) m[s] = 1'b1;
      v = ($urandom_range(0, 9) == 0) ? 8'h02 : 8'h01;
      t = ($urandom_range(0, 9) == 0) ? 8'h81 : 8'h01;
      r = ($urandom_range(0, 9) != 0);
      d = $urandom_range(0, T - 1);
      fill_random_dg();
      do_txn(s, v, t, m, r, d, (d >= 1) && ($urandom_range(0, 3) == 0),
             (d >= 1) && ($urandom_range(0, 3) == 0), "random");
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 300'(exp_q.size()), 300'(0));
    chk("req_count",   300'(req_cnt),      300'(exp_req));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
